// File: rtl/gtx_reset_seq.sv
// Reset sequencer for a GTXE2 channel and its user-clock PLL (gtrefclk domain).
// Orders cpllreset/txreset/rxreset, gates tx/rxuserrdy, supervises lock and
// resetdone with timeouts and bounded retries, and services OOB RX resets.
module gtx_reset_seq #(
  parameter int unsigned CPLLRST_LEN  = 8,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned TXPMA_WAIT   = 1,
  parameter int unsigned RXEYE_WAIT   = 35,
  parameter int unsigned DONE_TIMEOUT = 2048,
  parameter int unsigned RXRST_LEN    = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       gtrefclk,
  input  logic       extrst,
  input  logic       cplllock,
  input  logic       usrpll_locked,
  input  logic       txresetdone,
  input  logic       rxresetdone,
  input  logic       rxreset_req,
  output logic       cpllreset,
  output logic       txreset,
  output logic       rxreset,
  output logic       txuserrdy,
  output logic       rxuserrdy,
  output logic       gtx_ready,
  output logic       rxreset_ack,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam int unsigned MAX_A = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned MAX_B = (CPLLRST_LEN > RXRST_LEN) ? CPLLRST_LEN : RXRST_LEN;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_D = (MAX_C > RXEYE_WAIT + 1) ? MAX_C : RXEYE_WAIT + 1;
  localparam int unsigned CW    = $clog2(MAX_D + 1);

  localparam logic [2:0] ST_CPLL_RST  = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;
  localparam logic [2:0] ST_RX_RST    = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  // True in the last cycle of a len-cycle interval counted from cnt == 0.
  function automatic logic at_last(input logic [CW-1:0] c, input int unsigned len);
    return (32'(c) + 32'd1) >= len;
  endfunction

  logic [4:0]    async_in;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic          s_cplllock;
  logic          s_usrpll_locked;
  logic          s_txresetdone;
  logic          s_rxresetdone;
  logic          s_rxreset_req;
  logic          req_prev;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          do_retry;
  logic          cpllreset_nxt;
  logic          txreset_nxt;
  logic          rxreset_nxt;
  logic          txuserrdy_nxt;
  logic          rxuserrdy_nxt;
  logic          gtx_ready_nxt;
  logic          rxreset_ack_nxt;
  logic          fail_nxt;
  logic [1:0]    retry_cnt_nxt;

  assign async_in        = {cplllock, usrpll_locked, txresetdone, rxresetdone, rxreset_req};
  assign s_cplllock      = sync2[4];
  assign s_usrpll_locked = sync2[3];
  assign s_txresetdone   = sync2[2];
  assign s_rxresetdone   = sync2[1];
  assign s_rxreset_req   = sync2[0];
  assign state_dbg       = state;

  // Two-flop synchronisers plus the previous request level for edge detection.
  always_ff @(posedge gtrefclk or posedge extrst) begin
    if (extrst) begin
      sync1    <= '0;
      sync2    <= '0;
      req_prev <= 1'b0;
    end else begin
      sync1    <= async_in;
      sync2    <= sync1;
      req_prev <= s_rxreset_req;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge gtrefclk or posedge extrst) begin
    if (extrst) begin
      state       <= ST_CPLL_RST;
      cnt         <= '0;
      cpllreset   <= 1'b1;
      txreset     <= 1'b1;
      rxreset     <= 1'b1;
      txuserrdy   <= 1'b0;
      rxuserrdy   <= 1'b0;
      gtx_ready   <= 1'b0;
      rxreset_ack <= 1'b0;
      fail        <= 1'b0;
      retry_cnt   <= 2'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cpllreset   <= cpllreset_nxt;
      txreset     <= txreset_nxt;
      rxreset     <= rxreset_nxt;
      txuserrdy   <= txuserrdy_nxt;
      rxuserrdy   <= rxuserrdy_nxt;
      gtx_ready   <= gtx_ready_nxt;
      rxreset_ack <= rxreset_ack_nxt;
      fail        <= fail_nxt;
      retry_cnt   <= retry_cnt_nxt;
    end
  end

  // Next state and next output values; outputs change on state entry or sub-phase steps.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = (cnt == '1) ? cnt : cnt + CW'(1);
    do_retry        = 1'b0;
    cpllreset_nxt   = cpllreset;
    txreset_nxt     = txreset;
    rxreset_nxt     = rxreset;
    txuserrdy_nxt   = txuserrdy;
    rxuserrdy_nxt   = rxuserrdy;
    gtx_ready_nxt   = gtx_ready;
    rxreset_ack_nxt = 1'b0;
    fail_nxt        = fail;
    retry_cnt_nxt   = retry_cnt;

    case (state)
      ST_CPLL_RST: begin
        if (at_last(cnt, CPLLRST_LEN)) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (at_last(cnt, LOCK_TIMEOUT)) do_retry = 1'b1;
        else if (s_cplllock)            state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (cnt >= CW'(RXEYE_WAIT)) cnt_nxt = cnt;
        if (!s_cplllock) begin
          state_nxt = ST_CPLL_RST;
        end else begin
          if (s_usrpll_locked && (cnt >= CW'(TXPMA_WAIT))) txuserrdy_nxt = 1'b1;
          if (s_usrpll_locked && (cnt >= CW'(RXEYE_WAIT))) rxuserrdy_nxt = 1'b1;
          if (txuserrdy_nxt && rxuserrdy_nxt) state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!s_cplllock)                           state_nxt = ST_CPLL_RST;
        else if (at_last(cnt, DONE_TIMEOUT))       do_retry  = 1'b1;
        else if (s_txresetdone && s_rxresetdone)   state_nxt = ST_READY;
      end
      ST_READY: begin
        if (!s_cplllock)                           state_nxt = ST_CPLL_RST;
        else if (!s_usrpll_locked)                 state_nxt = ST_RELEASE;
        else if (s_rxreset_req && !req_prev)       state_nxt = ST_RX_RST;
      end
      ST_RX_RST: begin
        if (!s_cplllock) begin
          state_nxt = ST_CPLL_RST;
        end else if (!s_usrpll_locked) begin
          state_nxt = ST_RELEASE;
        end else if (rxreset) begin
          if (at_last(cnt, RXRST_LEN)) begin
            rxreset_nxt = 1'b0;
            cnt_nxt     = '0;
          end
        end else if (!rxuserrdy) begin
          if (at_last(cnt, RXEYE_WAIT)) begin
            rxuserrdy_nxt = 1'b1;
            cnt_nxt       = '0;
          end
        end else if (at_last(cnt, DONE_TIMEOUT)) begin
          do_retry = 1'b1;
        end else if (s_rxresetdone) begin
          state_nxt       = ST_READY;
          rxreset_ack_nxt = 1'b1;
        end
      end
      ST_FAIL: begin
        state_nxt = ST_FAIL;
      end
      default: begin
        state_nxt = ST_CPLL_RST;
      end
    endcase

    // Failed attempt: count it and either restart or give up.
    if (do_retry) begin
      retry_cnt_nxt = retry_cnt + 2'd1;
      state_nxt     = ((32'(retry_cnt) + 32'd1) >= MAX_RETRY) ? ST_FAIL : ST_CPLL_RST;
    end

    // Entry actions for the state being entered.
    if (state_nxt != state) begin
      cnt_nxt = '0;
      case (state_nxt)
        ST_CPLL_RST: begin
          cpllreset_nxt = 1'b1;
          txreset_nxt   = 1'b1;
          rxreset_nxt   = 1'b1;
          txuserrdy_nxt = 1'b0;
          rxuserrdy_nxt = 1'b0;
          gtx_ready_nxt = 1'b0;
        end
        ST_WAIT_LOCK: begin
          cpllreset_nxt = 1'b0;
        end
        ST_RELEASE: begin
          cpllreset_nxt = 1'b0;
          txreset_nxt   = 1'b0;
          rxreset_nxt   = 1'b0;
          txuserrdy_nxt = 1'b0;
          rxuserrdy_nxt = 1'b0;
          gtx_ready_nxt = 1'b0;
        end
        ST_READY: begin
          gtx_ready_nxt = 1'b1;
          retry_cnt_nxt = 2'd0;
        end
        ST_RX_RST: begin
          rxreset_nxt   = 1'b1;
          rxuserrdy_nxt = 1'b0;
          gtx_ready_nxt = 1'b0;
        end
        ST_FAIL: begin
          cpllreset_nxt = 1'b0;
          txreset_nxt   = 1'b1;
          rxreset_nxt   = 1'b1;
          txuserrdy_nxt = 1'b0;
          rxuserrdy_nxt = 1'b0;
          gtx_ready_nxt = 1'b0;
          fail_nxt      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
